// File: rtl/rand_pkg.sv
// Shared types and the reference step function for the parallel LFSR generator.
package rand_pkg;

  typedef enum logic {WARM = 1'b0, RUN = 1'b1} fsm_t;

  localparam int MAX_LEN = 64;
  localparam logic [62:0] DEFAULT_SEED_63 = 63'h1;

  // Runs n Fibonacci steps; bit i of state holds s[i+1]. hi/lo are 0-based tap indices.
  function automatic logic [MAX_LEN-1:0] lfsr_advance(input logic [MAX_LEN-1:0] state,
                                                      input int n,
                                                      input logic [5:0] hi,
                                                      input logic [5:0] lo);
    logic [MAX_LEN-1:0] s;
    logic               f;
    s = state;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < n) begin
        f = s[hi] ^ s[lo];
        s = {s[MAX_LEN-2:0], f};
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/rand_lfsr_par_unroll.sv
// Combinational OUT_W-step unroll of the LFSR: next state plus the new bits in step order.
module rand_lfsr_unroll
  import rand_pkg::*;
#(
  parameter int LFSR_LEN = 63,
  parameter int TAP_LO   = 62,
  parameter int OUT_W    = 16
) (
  input  logic [LFSR_LEN-1:0] s,
  output logic [LFSR_LEN-1:0] s_next,
  output logic [OUT_W-1:0]    bits
);

  logic [MAX_LEN-1:0] wide;

  assign wide   = lfsr_advance(MAX_LEN'(s), OUT_W, 6'(LFSR_LEN-1), 6'(TAP_LO-1));
  assign s_next = wide[LFSR_LEN-1:0];

  // After OUT_W shifts the first new bit sits highest among the fresh ones.
  for (genvar k = 0; k < OUT_W; k++) begin : g_bit
    assign bits[k] = wide[OUT_W-1-k];
  end

  if (LFSR_LEN < MAX_LEN) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^wide[MAX_LEN-1:LFSR_LEN];
  end

endmodule

// File: rtl/rand_lfsr_par.sv
// Parallel LFSR random-word generator with reseed, zero-seed guard, warm-up discard and valid strobe.
module rand_lfsr_par
  import rand_pkg::*;
#(
  parameter int                  OUT_W        = 16,
  parameter int                  LFSR_LEN     = 63,
  parameter int                  TAP_LO       = 62,
  parameter int                  WARMUP       = 64,
  parameter logic [LFSR_LEN-1:0] DEFAULT_SEED = LFSR_LEN'(DEFAULT_SEED_63)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                seed_load,
  input  logic [LFSR_LEN-1:0] seed_in,
  output logic [OUT_W-1:0]    rand_out,
  output logic                rand_valid,
  output logic                warming
);

  localparam int             WCW  = (WARMUP > 0) ? $clog2(WARMUP+1) : 1;
  localparam logic [WCW-1:0] WLIM = WCW'(WARMUP);

  fsm_t                fsm, fsm_nxt;
  logic [WCW-1:0]      wcnt, wcnt_nxt;
  logic [LFSR_LEN-1:0] s, s_next, seed_eff;
  logic [OUT_W-1:0]    bits;
  logic                advance;

  assign advance  = enable & ~seed_load;
  assign seed_eff = (seed_in == '0) ? DEFAULT_SEED : seed_in;
  assign warming  = (fsm == WARM);

  rand_lfsr_unroll #(
    .LFSR_LEN (LFSR_LEN),
    .TAP_LO   (TAP_LO),
    .OUT_W    (OUT_W)
  ) u_unroll (
    .s      (s),
    .s_next (s_next),
    .bits   (bits)
  );

  // Leaving WARM looks at the post-increment count, so the advance after the
  // last discarded one is already valid; WARMUP=0 exits after one idle edge.
  always_comb begin
    fsm_nxt  = fsm;
    wcnt_nxt = wcnt;
    if (seed_load) begin
      fsm_nxt  = WARM;
      wcnt_nxt = '0;
    end else if (fsm == WARM) begin
      if (advance && (wcnt != WLIM)) wcnt_nxt = wcnt + WCW'(1);
      if (wcnt_nxt == WLIM) fsm_nxt = RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s          <= DEFAULT_SEED;
      fsm        <= WARM;
      wcnt       <= '0;
      rand_out   <= '0;
      rand_valid <= 1'b0;
    end else begin
      fsm        <= fsm_nxt;
      wcnt       <= wcnt_nxt;
      rand_valid <= advance & (fsm == RUN);
      if (seed_load) begin
        s <= seed_eff;
      end else if (advance) begin
        s        <= s_next;
        rand_out <= bits;
      end
    end
  end

endmodule

// File: tb/tb_rand_lfsr_par.sv
// Scoreboard bench: a bit-recurrence model b[t] = b[t-63] ^ b[t-62] predicts four DUT variants.
module tb_rand_lfsr_par;

  localparam int ND = 4;

  typedef struct packed {
    logic [31:0] out;
    logic        valid;
    logic        warm;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, enable = 1'b0, seed_load = 1'b0;
  logic [62:0] seed_in = '0;
  logic [15:0] out_a, out_b;
  logic [0:0]  out_c;
  logic [31:0] out_d;
  logic        vld_a, vld_b, vld_c, vld_d, wrm_a, wrm_b, wrm_c, wrm_d;

  exp_t        expq [ND][$];
  bit          hist [ND][$];
  int          adv [ND], edges [ND];
  logic [31:0] last_out [ND];
  int          tests = 0, fails = 0, zrun = 0;

  always #5 clk = ~clk;

  rand_lfsr_par #(.OUT_W(16), .WARMUP(4)) dut_a (.clk(clk), .reset(reset), .enable(enable),
    .seed_load(seed_load), .seed_in(seed_in), .rand_out(out_a), .rand_valid(vld_a), .warming(wrm_a));
  rand_lfsr_par #(.OUT_W(16), .WARMUP(0)) dut_b (.clk(clk), .reset(reset), .enable(enable),
    .seed_load(seed_load), .seed_in(seed_in), .rand_out(out_b), .rand_valid(vld_b), .warming(wrm_b));
  rand_lfsr_par #(.OUT_W(1), .WARMUP(0)) dut_c (.clk(clk), .reset(reset), .enable(enable),
    .seed_load(seed_load), .seed_in(seed_in), .rand_out(out_c), .rand_valid(vld_c), .warming(wrm_c));
  rand_lfsr_par #(.OUT_W(32)) dut_d (.clk(clk), .reset(reset), .enable(enable),
    .seed_load(seed_load), .seed_in(seed_in), .rand_out(out_d), .rand_valid(vld_d), .warming(wrm_d));

  function automatic int wid(int d);
    case (d) 0, 1: return 16; 2: return 1; default: return 32; endcase
  endfunction

  function automatic int wup(int d);
    case (d) 0: return 4; 1, 2: return 0; default: return 64; endcase
  endfunction

  function automatic void sample(int d, output logic [31:0] o, output logic v, output logic w);
    case (d)
      0:       begin o = {16'h0, out_a}; v = vld_a; w = wrm_a; end
      1:       begin o = {16'h0, out_b}; v = vld_b; w = wrm_b; end
      2:       begin o = {31'h0, out_c}; v = vld_c; w = wrm_c; end
      default: begin o = out_d;          v = vld_d; w = wrm_d; end
    endcase
  endfunction

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h @%0t", nm, got, exp, $time);
    end
  endfunction

  // History holds the last 63 bits, oldest first; a zero seed is replaced by 1.
  function automatic void model_seed(int d, logic [62:0] sd);
    logic [62:0] v;
    v = (sd == '0) ? 63'h1 : sd;
    hist[d].delete();
    for (int j = 0; j < 63; j++) hist[d].push_back(v[62-j]);
    adv[d]   = 0;
    edges[d] = 0;
  endfunction

  function automatic logic [31:0] model_bits(int d, int n);
    logic [31:0] w;
    bit          b;
    w = '0;
    for (int k = 0; k < n; k++) begin
      b = hist[d][0] ^ hist[d][1];
      hist[d].push_back(b);
      void'(hist[d].pop_front());
      w = w | (32'(b) << k);
    end
    return w;
  endfunction

  // RUN means at least one edge since (re)seed and WARMUP advances consumed.
  function automatic void model_cycle(int d, logic r, logic en, logic sl, logic [62:0] sd);
    exp_t e;
    logic run;
    if (r) begin
      model_seed(d, 63'h1);
      last_out[d] = '0;
      e.out = '0; e.valid = 1'b0; e.warm = 1'b1;
    end else if (sl) begin
      model_seed(d, sd);
      e.out = last_out[d]; e.valid = 1'b0; e.warm = 1'b1;
    end else begin
      run = (edges[d] >= 1) && (adv[d] >= wup(d));
      e.valid = 1'b0;
      if (en) begin
        last_out[d] = model_bits(d, wid(d));
        e.valid     = run;
        adv[d]++;
      end
      edges[d]++;
      e.out  = last_out[d];
      e.warm = !(adv[d] >= wup(d));
    end
    expq[d].push_back(e);
  endfunction

  task automatic cyc(input logic r, input logic en, input logic sl, input logic [62:0] sd);
    @(negedge clk);
    reset = r; enable = en; seed_load = sl; seed_in = sd;
    for (int d = 0; d < ND; d++) model_cycle(d, r, en, sl, sd);
  endtask

  // Seed, one idle cycle, then five advances with directed word/valid/warm-up checks.
  task automatic known(input logic [62:0] sd);
    cyc(1'b0, 1'b0, 1'b1, sd);
    cyc(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      @(posedge clk); #1;
      if (i < 4) chk($sformatf("known word %0d", i), {16'h0, out_b}, (i == 3) ? 32'h6000 : 32'h0);
      chk($sformatf("known valid %0d", i), {31'h0, vld_b}, 32'h1);
      chk($sformatf("warmup valid %0d", i), {31'h0, vld_a}, (i == 4) ? 32'h1 : 32'h0);
      chk($sformatf("warmup warming %0d", i), {31'h0, wrm_a}, (i < 3) ? 32'h1 : 32'h0);
    end
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] o;
    logic        v, w;
    forever begin
      @(posedge clk); #1;
      for (int d = 0; d < ND; d++) begin
        if (expq[d].size() > 0) begin
          e = expq[d].pop_front();
          sample(d, o, v, w);
          chk($sformatf("dut%0d rand_out", d), o, e.out);
          chk($sformatf("dut%0d rand_valid", d), {31'h0, v}, {31'h0, e.valid});
          chk($sformatf("dut%0d warming", d), {31'h0, w}, {31'h0, e.warm});
          if (d == 0 && v) begin
            tests++;
            zrun = (o == 0) ? zrun + 1 : 0;
            if (zrun >= 4) begin
              fails++;
              $display("FAIL stuck-zero dut0 got=%0d zero words exp=<4", zrun);
            end
          end
        end
      end
    end
  end

  initial begin : stim
    logic [63:0] r64;
    logic [62:0] sd;
    logic        r, sl, en;
    logic [31:0] o;
    logic        v, w;

    repeat (3) cyc(1'b1, 1'b0, 1'b0, '0);
    repeat (150) cyc(1'b0, 1'($urandom_range(0, 3) != 0), 1'b0, '0);

    // Asynchronous reset between edges.
    cyc(1'b1, 1'b0, 1'b0, '0);
    #1;
    for (int d = 0; d < ND; d++) begin
      sample(d, o, v, w);
      chk($sformatf("async reset out dut%0d", d), o, 32'h0);
      chk($sformatf("async reset valid dut%0d", d), {31'h0, v}, 32'h0);
      chk($sformatf("async reset warming dut%0d", d), {31'h0, w}, 32'h1);
    end
    cyc(1'b0, 1'b0, 1'b0, '0);

    known(63'h1);
    known(63'h0);

    // Seed load collides with enable while in RUN.
    cyc(1'b0, 1'b1, 1'b1, 63'h1234_5678_9ABC_DEF0);
    @(posedge clk); #1;
    chk("collision valid", {31'h0, vld_b}, 32'h0);
    chk("collision warming", {31'h0, wrm_b}, 32'h1);

    for (int i = 0; i < 3000; i++) begin
      r64 = {$urandom(), $urandom()};
      sd  = ($urandom_range(0, 3) == 0) ? 63'h0 : r64[62:0];
      r   = ($urandom_range(0, 699) == 0);
      sl  = ($urandom_range(0, 249) == 0);
      en  = ($urandom_range(0, 9) < 7);
      cyc(r, en, sl, sd);
    end
    cyc(1'b0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #2;
    for (int d = 0; d < ND; d++) chk($sformatf("drain dut%0d", d), 32'(expq[d].size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
